// File: rtl/axi_req_arbiter.sv
// ============================================================================
// axi_req_arbiter
// ----------------------------------------------------------------------------
// Purpose
//   Merges two SRAM-like requesters onto a single downstream SRAM-like port
//   that feeds an AXI bridge:
//     m0 : instruction side, read-only
//     m1 : data side, read or write
//   The address phase is arbitrated combinationally, so an accepted request
//   costs no extra cycle. A small in-order FIFO remembers which requester
//   owns each outstanding transaction. Each downstream completion is then
//   steered back to the right requester.
//
// Configuration
//   ARB_ROUND_ROBIN_EN (macro)
//     defined   : after every accepted address, priority passes to the
//                 other requester (alternating grants under contention).
//     undefined : m1 has strict priority over m0 and there is no
//                 priority register.
//
// Parameters
//   DEPTH : maximum number of accepted-but-unanswered requests.
//           Must be a power of two, 2..8.
//
// Ports
//   aclk        in   1   clock, all state on the rising edge
//   aresetn     in   1   asynchronous active-low reset
//   m0_req      in   1   instruction request
//   m0_cmd      in   34  {size[1:0], addr[31:0]}
//   m0_addr_ok  out  1   m0 address accepted this cycle
//   m0_data_ok  out  1   m0 read data returned this cycle
//   m1_req      in   1   data request
//   m1_cmd      in   71  {wr, size[1:0], wstrb[3:0], addr[31:0], wdata[31:0]}
//   m1_addr_ok  out  1   m1 address accepted this cycle
//   m1_data_ok  out  1   m1 read data / write completion this cycle
//   m_rdata     out  32  shared return data (passthrough of s_rdata)
//   s_req       out  1   downstream request
//   s_cmd       out  71  downstream command in m1_cmd layout
//   s_addr_ok   in   1   downstream address accepted
//   s_data_ok   in   1   downstream response valid
//   s_rdata     in   32  downstream read data
//   err         out  1   sticky flag: response seen with nothing outstanding
//
// Downstream assumptions
//   The downstream side returns responses in acceptance order. It never
//   answers a request in the same cycle that request is accepted.
// ============================================================================
module axi_req_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        aclk,
    input  logic        aresetn,

    input  logic        m0_req,
    input  logic [33:0] m0_cmd,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,

    input  logic        m1_req,
    input  logic [70:0] m1_cmd,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,

    output logic [31:0] m_rdata,

    output logic        s_req,
    output logic [70:0] s_cmd,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    input  logic [31:0] s_rdata,

    output logic        err
);

    // ------------------------------------------------------------------------
    // Local sizing
    // ------------------------------------------------------------------------
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;   // pointer width
    localparam int CW = $clog2(DEPTH) + 1;                  // count holds 0..DEPTH

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ZERO_CNT = '0;

    // Requester IDs as stored in the outstanding FIFO
    localparam logic ID_M0 = 1'b0;
    localparam logic ID_M1 = 1'b1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [CW-1:0]    r_count;     // outstanding transactions
    logic [PW-1:0]    r_wptr;      // next FIFO slot to write
    logic [PW-1:0]    r_rptr;      // oldest outstanding slot
    logic [DEPTH-1:0] r_ids;       // one requester ID per slot
    logic             r_lock;      // address phase pending, grant frozen
    logic             r_lock_id;   // requester the grant is frozen to
    logic             r_err;       // sticky stray-response flag

    // ------------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------------
    logic        w_full;
    logic        w_empty;
    logic        w_any_req;
    logic        w_prio;       // preferred requester when both request
    logic        w_gnt;        // granted requester ID
    logic        w_sreq;
    logic [70:0] w_m0_cmd_ext; // m0 command widened to the m1 layout
    logic [70:0] w_cmd;
    logic        w_push;
    logic        w_pop;
    logic        w_stray;
    logic        w_head;       // owner of the response being returned

    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == ZERO_CNT);
    assign w_any_req = m0_req | m1_req;

    // ------------------------------------------------------------------------
    // Priority source
    // ------------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
    // Starts on m1. After each accepted address it flips to whichever
    // requester did not just win.
    logic r_prio;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_prio <= ID_M1;
        end else if (w_push) begin
            r_prio <= ~w_gnt;
        end
    end

    assign w_prio = r_prio;
`else
    // Fixed priority: the data side always wins under contention.
    assign w_prio = ID_M1;
`endif

    // ------------------------------------------------------------------------
    // Grant selection
    // While an address phase is stalled (request out, no s_addr_ok), the
    // grant stays on the requester already presented. This keeps s_cmd stable
    // for the bridge, even if the other requester arrives with higher
    // priority.
    // ------------------------------------------------------------------------
    always_comb begin
        w_gnt = ID_M0;
        if (r_lock) begin
            w_gnt = r_lock_id;
        end else if (m0_req && m1_req) begin
            w_gnt = w_prio;
        end else begin
            w_gnt = m1_req ? ID_M1 : ID_M0;
        end
    end

    // ------------------------------------------------------------------------
    // Downstream request and command mux
    // Outputs are forced low during reset so that nothing leaks out while
    // the block is held in reset, even though the path is combinational.
    // ------------------------------------------------------------------------
    assign w_sreq       = aresetn & w_any_req & ~w_full;
    assign w_m0_cmd_ext = {1'b0, m0_cmd[33:32], 4'b0000, m0_cmd[31:0], 32'h0000_0000};
    assign w_cmd        = (w_gnt == ID_M1) ? m1_cmd : w_m0_cmd_ext;

    assign s_req = w_sreq;
    assign s_cmd = aresetn ? w_cmd : '0;

    // ------------------------------------------------------------------------
    // Address-phase handshake back to the requesters
    // ------------------------------------------------------------------------
    assign w_push = w_sreq & s_addr_ok;

    assign m0_addr_ok = w_push & (w_gnt == ID_M0);
    assign m1_addr_ok = w_push & (w_gnt == ID_M1);

    // ------------------------------------------------------------------------
    // Response routing
    // An empty FIFO with a same-cycle push is the only case where the
    // response owner is not yet stored. The owner is then the ID being
    // pushed, so take it straight from the grant. A response with nothing
    // outstanding and nothing being pushed has no owner. Drop it and flag
    // the protocol error.
    // ------------------------------------------------------------------------
    assign w_head  = w_empty ? w_gnt : r_ids[r_rptr];
    assign w_pop   = aresetn & s_data_ok & (~w_empty | w_push);
    assign w_stray = aresetn & s_data_ok & w_empty & ~w_push;

    assign m0_data_ok = w_pop & (w_head == ID_M0);
    assign m1_data_ok = w_pop & (w_head == ID_M1);
    assign m_rdata    = s_rdata;

    assign err = r_err;

    // ------------------------------------------------------------------------
    // Outstanding-ID FIFO storage
    // Contents need no reset. Only the pointers and count decide which slots
    // are valid.
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_ids[r_wptr] <= w_gnt;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO pointers and occupancy
    // DEPTH is a power of two, so the pointers wrap naturally at their width.
    // A simultaneous push and pop advances both pointers and leaves the
    // count unchanged.
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Grant lock
    // Set whenever a request is presented but not accepted. Clears on
    // acceptance. Also clears when the FIFO is full, because s_req is then
    // low and nothing is being presented.
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_lock    <= 1'b0;
            r_lock_id <= ID_M0;
        end else begin
            r_lock    <= w_sreq & ~s_addr_ok;
            r_lock_id <= w_gnt;
        end
    end

    // ------------------------------------------------------------------------
    // Sticky error flag, cleared only by reset
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_err <= 1'b0;
        end else if (w_stray) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_req_arbiter.sv
// ============================================================================
// tb_axi_req_arbiter
// Directed scenarios followed by randomized traffic. Every DUT output is
// compared each cycle against a behavioural model built on a queue of
// outstanding requester IDs.
// ============================================================================
module tb_axi_req_arbiter;

    localparam int DEPTH = 4;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        m0_req, m1_req;
    logic [33:0] m0_cmd;
    logic [70:0] m1_cmd;
    logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
    logic [31:0] m_rdata;
    logic        s_req;
    logic [70:0] s_cmd;
    logic        s_addr_ok, s_data_ok;
    logic [31:0] s_rdata;
    logic        err;

    always #5 aclk = ~aclk;

    axi_req_arbiter #(.DEPTH(DEPTH)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .m0_req     (m0_req),
        .m0_cmd     (m0_cmd),
        .m0_addr_ok (m0_addr_ok),
        .m0_data_ok (m0_data_ok),
        .m1_req     (m1_req),
        .m1_cmd     (m1_cmd),
        .m1_addr_ok (m1_addr_ok),
        .m1_data_ok (m1_data_ok),
        .m_rdata    (m_rdata),
        .s_req      (s_req),
        .s_cmd      (s_cmd),
        .s_addr_ok  (s_addr_ok),
        .s_data_ok  (s_data_ok),
        .s_rdata    (s_rdata),
        .err        (err)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    bit mq[$];   // outstanding requester IDs, oldest first
    bit lk_v;    // previous cycle presented a request that was not accepted
    bit lk_id;   // requester presented in that cycle
    bit prio;    // preferred requester (round-robin build only)
    bit err_m;

    task automatic check_val(input string tag, input logic [70:0] got, input logic [70:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit mdl_gnt(input bit m0r, input bit m1r);
        if (lk_v) return lk_id;
        if (m0r && m1r) begin
`ifdef ARB_ROUND_ROBIN_EN
            return prio;
`else
            return 1'b1;
`endif
        end
        return m1r;
    endfunction

    function automatic bit mdl_sreq(input bit m0r, input bit m1r);
        return (m0r || m1r) && (mq.size() < DEPTH);
    endfunction

    task automatic mdl_clear();
        mq.delete();
        lk_v  = 1'b0;
        lk_id = 1'b0;
        prio  = 1'b1;
        err_m = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare every output, advance the model.
    task automatic step(input bit m0r, input bit m1r, input logic [33:0] c0,
                        input logic [70:0] c1, input bit saok, input bit sdok,
                        input logic [31:0] rd);
        bit g, sr, push, pop, head, stray;
        logic [70:0] ecmd;
        @(posedge aclk);
        #1;
        m0_req = m0r; m1_req = m1r; m0_cmd = c0; m1_cmd = c1;
        s_addr_ok = saok; s_data_ok = sdok; s_rdata = rd;
        #1;
        g     = mdl_gnt(m0r, m1r);
        sr    = mdl_sreq(m0r, m1r);
        push  = sr && saok;
        pop   = sdok && (mq.size() > 0 || push);
        head  = (mq.size() > 0) ? mq[0] : g;
        stray = sdok && (mq.size() == 0) && !push;
        ecmd  = g ? c1 : {1'b0, c0[33:32], 4'b0000, c0[31:0], 32'h0};

        check_val("s_req",      71'(s_req),      71'(sr));
        check_val("s_cmd",      s_cmd,           ecmd);
        check_val("m0_addr_ok", 71'(m0_addr_ok), 71'(push && !g));
        check_val("m1_addr_ok", 71'(m1_addr_ok), 71'(push && g));
        check_val("m0_data_ok", 71'(m0_data_ok), 71'(pop && !head));
        check_val("m1_data_ok", 71'(m1_data_ok), 71'(pop && head));
        check_val("m_rdata",    71'(m_rdata),    71'(rd));
        check_val("err",        71'(err),        71'(err_m));

        if (pop && mq.size() == 0) begin
            // Same-cycle bypass: the pushed ID is consumed at once.
        end else begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(g);
        end
        lk_v  = sr && !saok;
        lk_id = g;
        if (push) prio = !g;
        if (stray) err_m = 1'b1;
    endtask

    function automatic logic [33:0] rnd_c0();
        return {2'($urandom()), $urandom()};
    endfunction

    function automatic logic [70:0] rnd_c1();
        return {7'($urandom()), $urandom(), $urandom()};
    endfunction

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (mq.size() > 0) step(0, 0, rnd_c0(), rnd_c1(), 0, 1, $urandom());
        end
    endtask

    // Asserts reset part-way through a cycle while all inputs are active,
    // and checks that the outputs stay quiet across a clock edge.
    task automatic do_reset();
        @(posedge aclk);
        #3;
        m0_req = 1; m1_req = 1; s_addr_ok = 1; s_data_ok = 1;
        m0_cmd = rnd_c0(); m1_cmd = rnd_c1(); s_rdata = $urandom();
        aresetn = 0;
        #1;
        mdl_clear();
        for (int k = 0; k < 2; k++) begin
            check_val("rst_s_req",   71'(s_req),      71'(0));
            check_val("rst_s_cmd",   s_cmd,           71'(0));
            check_val("rst_m0_aok",  71'(m0_addr_ok), 71'(0));
            check_val("rst_m1_aok",  71'(m1_addr_ok), 71'(0));
            check_val("rst_m0_dok",  71'(m0_data_ok), 71'(0));
            check_val("rst_m1_dok",  71'(m1_data_ok), 71'(0));
            check_val("rst_err",     71'(err),        71'(0));
            check_val("rst_m_rdata", 71'(m_rdata),    71'(s_rdata));
            @(posedge aclk);
            #1;
        end
        @(negedge aclk);
        m0_req = 0; m1_req = 0; s_addr_ok = 0; s_data_ok = 0;
        aresetn = 1;
    endtask

    initial begin
        bit m0r, m1r, saok, sdok;
        aresetn = 0;
        m0_req = 0; m1_req = 0; m0_cmd = '0; m1_cmd = '0;
        s_addr_ok = 0; s_data_ok = 0; s_rdata = '0;
        mdl_clear();
        do_reset();

        // Contention with an always-ready downstream until the FIFO fills.
        for (int i = 0; i < DEPTH; i++) step(1, 1, rnd_c0(), rnd_c1(), 1, 0, $urandom());
        // Full: s_req must be low.
        step(1, 1, rnd_c0(), rnd_c1(), 1, 0, $urandom());
        // One response while full; it goes to the first-accepted ID.
        step(1, 1, rnd_c0(), rnd_c1(), 1, 1, $urandom());
        // The freed slot allows a request again.
        step(1, 1, rnd_c0(), rnd_c1(), 1, 0, $urandom());
        drain();

        // Stalled address phase: grant stays on m0 while m1 arrives.
        begin
            logic [33:0] c0h;
            c0h = rnd_c0();
            step(1, 0, c0h, rnd_c1(), 0, 0, $urandom());
            step(1, 1, c0h, rnd_c1(), 0, 0, $urandom());
            step(1, 1, c0h, rnd_c1(), 0, 0, $urandom());
            step(1, 1, c0h, rnd_c1(), 1, 0, $urandom());
            step(0, 1, rnd_c0(), rnd_c1(), 1, 0, $urandom());
        end
        drain();

        // Simultaneous push and pop with two outstanding.
        step(1, 0, rnd_c0(), rnd_c1(), 1, 0, $urandom());
        step(1, 0, rnd_c0(), rnd_c1(), 1, 0, $urandom());
        step(0, 1, rnd_c0(), rnd_c1(), 1, 1, 32'hDEADBEEF);
        drain();

        // Stray response with nothing outstanding: err sets and holds.
        step(0, 0, rnd_c0(), rnd_c1(), 0, 1, $urandom());
        for (int i = 0; i < 3; i++) step(0, 0, rnd_c0(), rnd_c1(), 0, 0, $urandom());

        // Reset in the middle of a burst, then a late response.
        step(1, 1, rnd_c0(), rnd_c1(), 1, 0, $urandom());
        step(1, 1, rnd_c0(), rnd_c1(), 1, 0, $urandom());
        do_reset();
        step(0, 0, rnd_c0(), rnd_c1(), 0, 1, $urandom());
        step(0, 0, rnd_c0(), rnd_c1(), 0, 0, $urandom());
        do_reset();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            m0r  = ($urandom_range(0, 99) < 60);
            m1r  = ($urandom_range(0, 99) < 60);
            saok = ($urandom_range(0, 99) < 50);
            if (mq.size() > 0)
                sdok = ($urandom_range(0, 99) < 40);
            else if (!(mdl_sreq(m0r, m1r) && saok))
                sdok = ($urandom_range(0, 99) < 3);
            else
                sdok = 1'b0;
            step(m0r, m1r, rnd_c0(), rnd_c1(), saok, sdok, $urandom());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
